// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared types and constants for the MEM-stage access unit.
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

  // Access FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  // RV32I load/store funct3 encodings.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Access size field, funct3[1:0].
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Active-low "no lane" masks.
  localparam logic [3:0] WEB_NONE = 4'b1111;
  localparam logic [3:0] REB_NONE = 4'b1111;

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_lane_align
// Purpose  : Byte-lane mask, store-data replication and legality check for
//            one load/store request (purely combinational).
// Revision : 1.0 - initial release
// ============================================================================
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [31:0] rs2_data,
  output logic [3:0]  lane_mask,
  output logic [31:0] wdata,
  output logic        bad
);

  logic illegal;
  logic misaligned;

  // Decode size into an active-low lane mask, replicate narrow store data
  // across all lanes (which equals the lane shift for aligned accesses), and
  // flag illegal or misaligned encodings.
  always_comb begin
    illegal    = (funct3[1:0] == 2'b11)
               | (is_load  & (funct3[2:1] == 2'b11))
               | (is_store & funct3[2]);
    misaligned = 1'b0;
    lane_mask  = 4'b0000;
    wdata      = rs2_data;
    case (funct3[1:0])
      SZ_B: begin
        lane_mask = ~(4'b0001 << lane);
        wdata     = {4{rs2_data[7:0]}};
      end
      SZ_H: begin
        lane_mask  = ~(4'b0011 << lane);
        wdata      = {2{rs2_data[15:0]}};
        misaligned = lane[0];
      end
      SZ_W: begin
        misaligned = (lane != 2'b00);
      end
      default: begin
        lane_mask = 4'b0000;
      end
    endcase
    bad = illegal | misaligned;
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : MEM-stage load/store controller. Issues a req/ack data-memory
//            transaction with byte-lane steering, stalls the pipeline until
//            ack or timeout, and returns the raw read word for write-back.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit
  import mem_pkg::*;
#(
  parameter  int TIMEOUT = 16,
  localparam int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_MemRead,
  input  logic        mem_MemWrite,
  input  logic        mem_NoP_en,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] mem_ALU_out,
  input  logic [31:0] mem_rs2_data,
  output logic        dm_req,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_web,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        stall,
  output logic [31:0] mem_ReadData,
  output logic [3:0]  mem_REB_dm,
  output logic        mem_Read_Un,
  output logic        misalign,
  output logic        bus_err
);

  mem_state_e        state;
  mem_state_e        next_state;
  logic [CNT_W-1:0]  cnt;
  logic              req_load;

  logic              load;
  logic              store;
  logic              acc;
  logic              bad;
  logic [3:0]        lane_mask;
  logic [31:0]       st_data;

  logic              issue;
  logic              ack_hit;
  logic              to_hit;
  logic              bad_hit;

  // Load has priority when both strobes are set; a bubble kills both.
  assign load  = mem_MemRead & ~mem_NoP_en;
  assign store = mem_MemWrite & ~mem_MemRead & ~mem_NoP_en;
  assign acc   = load | store;

  mem_lane_align u_align (
    .funct3   (mem_funct3),
    .lane     (mem_ALU_out[1:0]),
    .is_load  (load),
    .is_store (store),
    .rs2_data (mem_rs2_data),
    .lane_mask(lane_mask),
    .wdata    (st_data),
    .bad      (bad)
  );

  // Pipeline-facing combinational outputs. Stall drops immediately on reset
  // so a dropped in-flight access does not keep the pipeline frozen.
  assign stall       = ~rst & (((state == IDLE) & acc & ~bad) | (state == REQ));
  assign mem_REB_dm  = (load & ~bad) ? lane_mask : REB_NONE;
  assign mem_Read_Un = load & mem_funct3[2];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state decode plus one-cycle event strobes for the datapath.
  always_comb begin
    next_state = state;
    issue      = 1'b0;
    ack_hit    = 1'b0;
    to_hit     = 1'b0;
    bad_hit    = 1'b0;
    case (state)
      IDLE: begin
        if (acc) begin
          if (bad) begin
            bad_hit = 1'b1;
          end else begin
            issue      = 1'b1;
            next_state = REQ;
          end
        end
      end
      REQ: begin
        if (dm_ack) begin
          ack_hit    = 1'b1;
          next_state = DONE;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          to_hit     = 1'b1;
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Memory request port: captured on issue, held stable through REQ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dm_req   <= 1'b0;
      dm_addr  <= 32'h0;
      dm_web   <= WEB_NONE;
      dm_wdata <= 32'h0;
      req_load <= 1'b0;
    end else if (issue) begin
      dm_req   <= 1'b1;
      dm_addr  <= {mem_ALU_out[31:2], 2'b00};
      dm_web   <= load ? WEB_NONE : lane_mask;
      dm_wdata <= st_data;
      req_load <= load;
    end else if (ack_hit || to_hit) begin
      dm_req   <= 1'b0;
    end
  end

  // Timeout counter: zero on issue, counts every REQ cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= '0;
    else if (issue)         cnt <= '0;
    else if (state == REQ)  cnt <= cnt + 1'b1;
  end

  // Read data capture: load data on ack, zero on timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      mem_ReadData <= 32'h0;
    else if (ack_hit && req_load) mem_ReadData <= dm_rdata;
    else if (to_hit)              mem_ReadData <= 32'h0;
  end

  // Single-cycle error pulses toward the trap path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      misalign <= bad_hit;
      bus_err  <= to_hit;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Self-checking bench for mem_access_unit with a result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_MemRead, mem_MemWrite, mem_NoP_en;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_ALU_out, mem_rs2_data;
  logic        dm_req;
  logic [31:0] dm_addr;
  logic [3:0]  dm_web;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;
  logic        stall;
  logic [31:0] mem_ReadData;
  logic [3:0]  mem_REB_dm;
  logic        mem_Read_Un, misalign, bus_err;

  mem_access_unit #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .mem_NoP_en(mem_NoP_en),
    .mem_funct3(mem_funct3), .mem_ALU_out(mem_ALU_out), .mem_rs2_data(mem_rs2_data),
    .dm_req(dm_req), .dm_addr(dm_addr), .dm_web(dm_web), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack), .stall(stall),
    .mem_ReadData(mem_ReadData), .mem_REB_dm(mem_REB_dm), .mem_Read_Un(mem_Read_Un),
    .misalign(misalign), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_rdata = 32'h0;

  int          n_stall, n_req;
  logic        done;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_web;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic nop,
                       input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    mem_MemRead = rd; mem_MemWrite = wr; mem_NoP_en = nop;
    mem_funct3 = f3; mem_ALU_out = addr; mem_rs2_data = wd;
    #1;
  endtask

  task automatic idle_inputs();
    drive(1'b0, 1'b0, 1'b0, F3_W, 32'h0, 32'h0);
  endtask

  // Memory responder: acks in the ack_at-th REQ cycle (0 = never), counts
  // stall and request cycles, and returns in the cycle the access completes.
  task automatic do_access(input int ack_at, input logic [31:0] rdata);
    n_stall = 0; n_req = 0; done = 1'b0;
    for (int c = 0; c < 64; c++) begin
      if (stall) n_stall++;
      if (dm_req) begin
        n_req++;
        if (n_req == 1) begin
          cap_addr = dm_addr; cap_web = dm_web; cap_wdata = dm_wdata;
        end
        if (n_req == ack_at) begin
          dm_ack = 1'b1; dm_rdata = rdata;
        end
      end
      if (!stall && !dm_req && n_stall > 0) begin
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
      dm_ack = 1'b0; dm_rdata = 32'h0BAD_0BAD;
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; dm_ack = 1'b0; dm_rdata = 32'h0;
    idle_inputs();
    step(); step();
    n_checks++; if (dm_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", dm_req); end
    n_checks++; if (dm_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", dm_addr); end
    n_checks++; if (dm_web !== 4'b1111) begin n_fail++; $display("FAIL rst_web: got %b want 1111", dm_web); end
    n_checks++; if (dm_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_wdata: got %h want 0", dm_wdata); end
    n_checks++; if (mem_ReadData !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", mem_ReadData); end
    n_checks++; if ({misalign, bus_err, stall} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %b want 000", {misalign, bus_err, stall}); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_load_word();
    exp_t e;
    drive(1'b1, 1'b0, 1'b0, F3_W, 32'h0000_1004, 32'h0);
    n_checks++; if (mem_REB_dm !== 4'b0000) begin n_fail++; $display("FAIL lw_reb: got %b want 0000", mem_REB_dm); end
    model_rdata = 32'hDEAD_BEEF;
    sb.push_back('{model_rdata, 1'b0});
    do_access(1, 32'hDEAD_BEEF);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL lw_done: got %b want 1", done); end
    n_checks++; if (n_stall != 2) begin n_fail++; $display("FAIL lw_stall: got %0d want 2", n_stall); end
    n_checks++; if (cap_addr !== 32'h0000_1004) begin n_fail++; $display("FAIL lw_addr: got %h want 00001004", cap_addr); end
    n_checks++; if (cap_web !== 4'b1111) begin n_fail++; $display("FAIL lw_web: got %b want 1111", cap_web); end
    e = sb.pop_front();
    n_checks++; if (mem_ReadData !== e.data) begin n_fail++; $display("FAIL lw_data: got %h want %h", mem_ReadData, e.data); end
    n_checks++; if (bus_err !== e.err) begin n_fail++; $display("FAIL lw_buserr: got %b want %b", bus_err, e.err); end
    idle_inputs(); step();
  endtask

  task automatic test_store();
    logic [2:0]  f3 [2];
    logic [31:0] ad [2], wd [2], ew [2];
    logic [3:0]  eb [2];
    int          ak [2];
    exp_t        e;
    f3[0] = F3_B; ad[0] = 32'h0000_2003; wd[0] = 32'h0000_00A5; eb[0] = 4'b0111; ew[0] = 32'hA5A5_A5A5; ak[0] = 3;
    f3[1] = F3_H; ad[1] = 32'h0000_2002; wd[1] = 32'h1234_5678; eb[1] = 4'b0011; ew[1] = 32'h5678_5678; ak[1] = 1;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b0, f3[i], ad[i], wd[i]);
      n_checks++; if (mem_REB_dm !== 4'b1111) begin n_fail++; $display("FAIL st%0d_reb: got %b want 1111", i, mem_REB_dm); end
      sb.push_back('{model_rdata, 1'b0});
      do_access(ak[i], 32'hFFFF_FFFF);
      n_checks++; if (n_stall != ak[i] + 1) begin n_fail++; $display("FAIL st%0d_stall: got %0d want %0d", i, n_stall, ak[i] + 1); end
      n_checks++; if (cap_addr !== 32'h0000_2000) begin n_fail++; $display("FAIL st%0d_addr: got %h want 00002000", i, cap_addr); end
      n_checks++; if (cap_web !== eb[i]) begin n_fail++; $display("FAIL st%0d_web: got %b want %b", i, cap_web, eb[i]); end
      n_checks++; if (cap_wdata !== ew[i]) begin n_fail++; $display("FAIL st%0d_wdata: got %h want %h", i, cap_wdata, ew[i]); end
      e = sb.pop_front();
      n_checks++; if (mem_ReadData !== e.data) begin n_fail++; $display("FAIL st%0d_data: got %h want %h", i, mem_ReadData, e.data); end
      idle_inputs(); step();
    end
  endtask

  task automatic test_misalign();
    exp_t e;
    // LHU at an odd address.
    drive(1'b1, 1'b0, 1'b0, F3_HU, 32'h0000_3001, 32'h0);
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mis_stall: got %b want 0", stall); end
    n_checks++; if (mem_REB_dm !== 4'b1111) begin n_fail++; $display("FAIL mis_reb: got %b want 1111", mem_REB_dm); end
    n_checks++; if (mem_Read_Un !== 1'b1) begin n_fail++; $display("FAIL mis_un: got %b want 1", mem_Read_Un); end
    step(); idle_inputs();
    n_checks++; if ({misalign, dm_req} !== 2'b10) begin n_fail++; $display("FAIL mis_pulse: got %b want 10", {misalign, dm_req}); end
    step();
    n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL mis_clear: got %b want 0", misalign); end
    // Store with funct3[2] set is illegal.
    drive(1'b0, 1'b1, 1'b0, 3'b110, 32'h0000_3000, 32'h1);
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL ill_stall: got %b want 0", stall); end
    step(); idle_inputs();
    n_checks++; if ({misalign, dm_req} !== 2'b10) begin n_fail++; $display("FAIL ill_pulse: got %b want 10", {misalign, dm_req}); end
    step();
    // Aligned LH on the upper half.
    drive(1'b1, 1'b0, 1'b0, F3_H, 32'h0000_3002, 32'h0);
    n_checks++; if (mem_REB_dm !== 4'b0011) begin n_fail++; $display("FAIL lh_reb: got %b want 0011", mem_REB_dm); end
    n_checks++; if (mem_Read_Un !== 1'b0) begin n_fail++; $display("FAIL lh_un: got %b want 0", mem_Read_Un); end
    model_rdata = 32'h8001_0000;
    sb.push_back('{model_rdata, 1'b0});
    do_access(2, 32'h8001_0000);
    e = sb.pop_front();
    n_checks++; if (mem_ReadData !== e.data) begin n_fail++; $display("FAIL lh_data: got %h want %h", mem_ReadData, e.data); end
    idle_inputs(); step();
  endtask

  task automatic test_timeout();
    exp_t e;
    drive(1'b1, 1'b0, 1'b0, F3_W, 32'h0000_0040, 32'h0);
    model_rdata = 32'h0;
    sb.push_back('{model_rdata, 1'b1});
    do_access(0, 32'h0);
    n_checks++; if (n_req != 16) begin n_fail++; $display("FAIL to_req: got %0d want 16", n_req); end
    n_checks++; if (n_stall != 17) begin n_fail++; $display("FAIL to_stall: got %0d want 17", n_stall); end
    e = sb.pop_front();
    n_checks++; if (bus_err !== e.err) begin n_fail++; $display("FAIL to_buserr: got %b want %b", bus_err, e.err); end
    n_checks++; if (mem_ReadData !== e.data) begin n_fail++; $display("FAIL to_data: got %h want %h", mem_ReadData, e.data); end
    idle_inputs(); step();
    n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL to_pulse: got %b want 0", bus_err); end
  endtask

  task automatic test_ack_at_timeout();
    exp_t e;
    drive(1'b1, 1'b0, 1'b0, F3_W, 32'h0000_0044, 32'h0);
    model_rdata = 32'h1234_5678;
    sb.push_back('{model_rdata, 1'b0});
    do_access(16, 32'h1234_5678);
    n_checks++; if (n_req != 16) begin n_fail++; $display("FAIL ackto_req: got %0d want 16", n_req); end
    e = sb.pop_front();
    n_checks++; if (bus_err !== e.err) begin n_fail++; $display("FAIL ackto_buserr: got %b want %b", bus_err, e.err); end
    n_checks++; if (mem_ReadData !== e.data) begin n_fail++; $display("FAIL ackto_data: got %h want %h", mem_ReadData, e.data); end
    idle_inputs(); step();
  endtask

  task automatic test_spurious_ack();
    dm_ack = 1'b1; dm_rdata = 32'hFFFF_0000;
    step();
    dm_ack = 1'b0;
    n_checks++; if ({dm_req, stall, bus_err} !== 3'b000) begin n_fail++; $display("FAIL spur_flags: got %b want 000", {dm_req, stall, bus_err}); end
    n_checks++; if (mem_ReadData !== model_rdata) begin n_fail++; $display("FAIL spur_data: got %h want %h", mem_ReadData, model_rdata); end
    step();
    n_checks++; if (dm_req !== 1'b0) begin n_fail++; $display("FAIL spur_req: got %b want 0", dm_req); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 1'b0, F3_W, 32'h0000_0050, 32'h0);
    step();
    n_checks++; if (dm_req !== 1'b1) begin n_fail++; $display("FAIL rmid_req_on: got %b want 1", dm_req); end
    rst = 1'b1; #1;
    n_checks++; if ({dm_req, stall} !== 2'b00) begin n_fail++; $display("FAIL rmid_drop: got %b want 00", {dm_req, stall}); end
    n_checks++; if (dm_addr !== 32'h0 || mem_ReadData !== 32'h0) begin n_fail++; $display("FAIL rmid_regs: got %h/%h want 0/0", dm_addr, mem_ReadData); end
    model_rdata = 32'h0;
    idle_inputs(); step();
    rst = 1'b0; step();
    n_checks++; if (dm_req !== 1'b0) begin n_fail++; $display("FAIL rmid_idle: got %b want 0", dm_req); end
  endtask

  task automatic test_nop();
    exp_t e;
    drive(1'b1, 1'b0, 1'b1, F3_BU, 32'h0000_0060, 32'h0);
    n_checks++; if ({mem_REB_dm, mem_Read_Un, stall} !== 6'b111100) begin n_fail++; $display("FAIL nop_comb: got %b want 111100", {mem_REB_dm, mem_Read_Un, stall}); end
    step();
    n_checks++; if ({dm_req, misalign} !== 2'b00) begin n_fail++; $display("FAIL nop_req: got %b want 00", {dm_req, misalign}); end
    // LBU on lane 1 right behind the bubble.
    drive(1'b1, 1'b0, 1'b0, F3_BU, 32'h0000_0071, 32'h0);
    n_checks++; if ({mem_REB_dm, mem_Read_Un} !== 5'b11011) begin n_fail++; $display("FAIL lbu_comb: got %b want 11011", {mem_REB_dm, mem_Read_Un}); end
    model_rdata = 32'h0000_7700;
    sb.push_back('{model_rdata, 1'b0});
    do_access(1, 32'h0000_7700);
    e = sb.pop_front();
    n_checks++; if (cap_addr !== 32'h0000_0070) begin n_fail++; $display("FAIL lbu_addr: got %h want 00000070", cap_addr); end
    n_checks++; if (mem_ReadData !== e.data) begin n_fail++; $display("FAIL lbu_data: got %h want %h", mem_ReadData, e.data); end
    idle_inputs(); step();
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_store();
    test_misalign();
    test_timeout();
    test_ack_at_timeout();
    test_spurious_ack();
    test_reset_mid();
    test_nop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store controller between the EX/MEM register and the MEM/WB register.
- Converts the pipeline's load/store request into a req/ack data-memory transaction with byte-lane steering.
- Stalls the pipeline until the access completes or times out.
- Produces the raw read word plus the byte-read mask and unsigned flag that the MEM/WB register carries to write-back.

Parameters:
TIMEOUT, 16, max cycles dm_req stays high without dm_ack before the access is aborted (>=1)
CNT_W, $clog2(TIMEOUT+1), timeout counter width (derived, not overridden)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
mem_MemRead  in  1  load in MEM stage
mem_MemWrite  in  1  store in MEM stage
mem_NoP_en  in  1  bubble; suppresses any access
mem_funct3  in  3  access size/sign (RV32I load/store encoding)
mem_ALU_out  in  32  effective byte address
mem_rs2_data  in  32  store data (unshifted)
dm_req  out  1  memory request, held until ack/abort
dm_addr  out  32  word-aligned address {addr[31:2],2'b00}
dm_web  out  4  active-low byte write enables; 4'b1111 = read
dm_wdata  out  32  lane-shifted store data
dm_rdata  in  32  read data, valid with dm_ack
dm_ack  in  1  single-cycle completion strobe
stall  out  1  freeze IF..MEM; do not advance EX/MEM or MEM/WB
mem_ReadData  out  32  raw read word latched on ack
mem_REB_dm  out  4  active-low byte-read mask; 4'b1111 = no read
mem_Read_Un  out  1  zero-extend load (LBU/LHU)
misalign  out  1  one-cycle pulse: misaligned or illegal funct3
bus_err  out  1  one-cycle pulse: access timed out

Behaviour:
- acc = (mem_MemRead | mem_MemWrite) & ~mem_NoP_en. MemRead has priority if both are set.
- Size: funct3[1:0] 00 = byte, 01 = half, 10 = word. funct3[2] = unsigned, loads only.
- Illegal encodings: x11; 11x on loads; 1xx on stores.
- Misaligned: half with addr[0]=1; word with addr[1:0]!=0.
- bad = misaligned or illegal.
- Lane masks (active-low, lane = addr[1:0]):
  - byte: bit lane low
  - half: bits lane and lane+1 low
  - word: 4'b0000
- Store data: dm_wdata = rs2_data << (8*lane), with byte/half replicated into the unused lanes.
- FSM states: IDLE, REQ, DONE. All dm_* outputs, mem_ReadData, misalign and bus_err are registered.
- IDLE:
  - acc & ~bad: next state REQ. Latch dm_addr, dm_web (read → 4'b1111), dm_wdata. dm_req=1 next cycle. Clear the counter.
  - acc & bad: stay IDLE, pulse misalign next cycle, no request, no stall. The instruction retires as a NoP; the trap path handles it.
- REQ: dm_req=1 with all dm_* held stable. The counter increments each cycle.
  - dm_ack: go to DONE, dm_req=0. On a load, latch mem_ReadData <= dm_rdata.
  - Counter reaches TIMEOUT-1 without ack: go to DONE, dm_req=0, pulse bus_err, mem_ReadData <= 0.
  - Ack and timeout in the same cycle: ack wins, no bus_err.
- DONE: one cycle, then IDLE. The pipeline advances this cycle, so the access is not re-issued.
- stall is combinational: (IDLE & acc & ~bad) | REQ. It is 0 in DONE and for NoP/bad accesses.
- mem_REB_dm = load & ~bad ? lane mask : 4'b1111. mem_Read_Un = load & funct3[2]. Both are combinational from current MEM-stage inputs.
- Latency: a zero-wait memory (ack in the first REQ cycle) gives 2 stall cycles; data is valid in DONE.
- dm_ack in IDLE or DONE is ignored.
- Reset values, including reset mid-access: state IDLE, dm_req 0, dm_addr 0, dm_web 4'b1111, dm_wdata 0, mem_ReadData 0, misalign 0, bus_err 0, counter 0. An in-flight transaction is dropped.

Decomposition:
- Shared package mem_pkg:
  - state enum mem_state_e {IDLE, REQ, DONE}
  - funct3 constants F3_B/H/W/BU/HU
  - localparams WEB_NONE = 4'b1111, REB_NONE = 4'b1111
- Sub-module mem_lane_align: combinational mask generation, store-data replication/shift and the bad check.

Test Plan:
- LW addr 0x0000_1004, ack in the 1st REQ cycle, rdata 0xDEAD_BEEF → dm_addr 0x1004, dm_web 4'b1111, stall for 2 cycles, mem_ReadData 0xDEADBEEF in DONE, mem_REB_dm 4'b0000.
- SB rs2 0x0000_00A5 at addr 0x2003, ack after 3 cycles → dm_web 4'b0111, dm_wdata 0xA5A5_A5A5, dm_addr 0x2000, stall 4 cycles.
- LHU addr 0x3001 → misalign pulses 1 cycle, dm_req stays 0, stall 0. LH addr 0x3002 → mem_REB_dm 4'b0011, mem_Read_Un 0.
- LW, never acked, TIMEOUT=16 → dm_req high exactly 16 cycles, bus_err 1-cycle pulse, mem_ReadData 0, stall releases.
- dm_ack coinciding with the final timeout cycle → no bus_err, data latched. Spurious dm_ack in IDLE → no state change.
- rst asserted in REQ → same cycle dm_req=0, stall=0, state IDLE. A mem_NoP_en=1 load → no request, mem_REB_dm 4'b1111.
